binary_to_gray_smoother: RTL and testbench

//  Turns the thresholded binary pixel stream (each pixel 0 or 4095) back into 12-bit gray.

---
 rtl/bin2gray_pkg.sv | 24 ++
 rtl/line_gap_detector.sv | 55 +++++
 rtl/binary_to_gray_smoother.sv | 76 +++++++
 tb/tb_binary_to_gray_smoother.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/bin2gray_pkg.sv
// Shared types and helpers for the binary-to-gray smoother.
package bin2gray_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned WIN_LOG2_DEF = 3;
    localparam int unsigned WIN          = 1 << WIN_LOG2_DEF;
    localparam int unsigned SUM_W        = WIN_LOG2_DEF + 1;
    localparam int unsigned SHIFT        = 12 - WIN_LOG2_DEF;

    // A full window saturates to 4095; otherwise the count is scaled by 4096/WIN.
    function automatic logic [11:0] scale_sum(input logic [6:0] sum, input int unsigned winLog2);
        logic [11:0] sum12;
        sum12 = {5'b0, sum};
        if (32'(sum) == (32'd1 << winLog2)) begin
            return 12'hFFF;
        end
        return sum12 << (12 - winLog2);
    endfunction

endpackage

// File: rtl/line_gap_detector.sv
// Tracks line activity from iDVAL: flags the first valid pixel of a line and the
// cycle on which an iDVAL-low run reaches GAP_CYC.
module line_gap_detector
    import bin2gray_pkg::*;
#(
    parameter int unsigned GAP_CYC = 4
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iDVAL,
    output logic lineStart,
    output logic lineEnd
);

    localparam logic [7:0] GapLast = 8'(GAP_CYC - 1);
    localparam logic [7:0] GapSat  = 8'(GAP_CYC);

    state_t     state;
    logic [7:0] gapCnt;

    assign lineStart = (state == IDLE) && iDVAL;
    // A valid pixel on the would-be terminating cycle keeps the line alive.
    assign lineEnd   = (state == RUN) && !iDVAL && (gapCnt == GapLast);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state  <= IDLE;
            gapCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (iDVAL) begin
                        state  <= RUN;
                        gapCnt <= '0;
                    end
                end
                RUN: begin
                    if (iDVAL) begin
                        gapCnt <= '0;
                    end else if (lineEnd) begin
                        state  <= IDLE;
                        gapCnt <= GapSat;
                    end else begin
                        gapCnt <= gapCnt + 8'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    gapCnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/binary_to_gray_smoother.sv
// Reconstructs gray from a thresholded pixel stream as white density over a sliding window.
// Define BIN2GRAY_EDGE_REPLICATE_EN to fill the whole window with a line's first pixel.
module binary_to_gray_smoother
    import bin2gray_pkg::*;
#(
    parameter int unsigned WIN_LOG2 = 3,
    parameter int unsigned GAP_CYC  = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iDVAL,
    input  logic [11:0] iDATA,
    output logic        oDVAL,
    output logic [11:0] oDATA
);

    localparam int unsigned WinLen = 1 << WIN_LOG2;
    localparam int unsigned SumW   = WIN_LOG2 + 1;

    logic              pixBit;
    logic              oldest;
    logic [WinLen-1:0] window;
    logic [SumW-1:0]   sum;
    logic              valid1;
    logic              lineStart;
    logic              lineEnd;
    logic              unusedData;

    assign pixBit     = iDATA[11];
    assign oldest     = window[WinLen-1];
    assign unusedData = ^iDATA[10:0];

    line_gap_detector #(
        .GAP_CYC(GAP_CYC)
    ) uGap (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iDVAL    (iDVAL),
        .lineStart(lineStart),
        .lineEnd  (lineEnd)
    );

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            window <= '0;
            sum    <= '0;
            valid1 <= 1'b0;
            oDVAL  <= 1'b0;
            oDATA  <= '0;
        end else begin
            valid1 <= iDVAL;
            if (lineStart) begin
`ifdef BIN2GRAY_EDGE_REPLICATE_EN
                window <= {WinLen{pixBit}};
                sum    <= pixBit ? SumW'(WinLen) : '0;
`else
                window <= {{(WinLen-1){1'b0}}, pixBit};
                sum    <= SumW'(pixBit);
`endif
            end else if (iDVAL) begin
                window <= {window[WinLen-2:0], pixBit};
                sum    <= sum + SumW'(pixBit) - SumW'(oldest);
            end else if (lineEnd) begin
                // Idle with a clean window; the next line start reloads it anyway.
                window <= '0;
                sum    <= '0;
            end

            oDVAL <= valid1;
            if (valid1) begin
                oDATA <= scale_sum(7'(sum), WIN_LOG2);
            end
        end
    end

endmodule

// File: tb/tb_binary_to_gray_smoother.sv
// Randomized and directed bench for binary_to_gray_smoother against a line-history model.
module tb_binary_to_gray_smoother;

    localparam int WIN_LOG2 = 3;
    localparam int GAP_CYC  = 4;
    localparam int WIN      = 1 << WIN_LOG2;

    logic        iCLK;
    logic        iRST;
    logic        iDVAL;
    logic [11:0] iDATA;
    logic        oDVAL;
    logic [11:0] oDATA;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: pixel history of the current line plus a 2-deep output delay line.
    int   lineBits[$];
    int   firstBit   = 0;
    bit   lineActive = 0;
    int   gapRun     = 0;
    logic pV1        = 1'b0;
    int   pD1        = 0;
    logic expV       = 1'b0;
    int   expD       = 0;

    binary_to_gray_smoother #(
        .WIN_LOG2(WIN_LOG2),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .iDVAL(iDVAL),
        .iDATA(iDATA),
        .oDVAL(oDVAL),
        .oDATA(oDATA)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            passCount++;
        end
    endtask

    function automatic int modelGray();
        int cnt = 0;
        for (int i = 0; i < WIN; i++) begin
            int idx = lineBits.size() - 1 - i;
            if (idx >= 0) begin
                cnt += lineBits[idx];
            end else begin
`ifdef BIN2GRAY_EDGE_REPLICATE_EN
                cnt += firstBit;
`else
                cnt += 0;
`endif
            end
        end
        if (cnt == WIN) return 4095;
        return (cnt * 4096) / WIN;
    endfunction

    task automatic stepPixel(input string tag, input logic v, input logic b);
        iDVAL = v;
        iDATA = {b, 11'($urandom)};
        @(posedge iCLK);
        expV = pV1;
        if (pV1) expD = pD1;
        if (v) begin
            if (!lineActive) begin
                lineBits.delete();
                lineActive = 1;
                firstBit   = int'(b);
            end
            lineBits.push_back(int'(b));
            if (lineBits.size() > WIN) void'(lineBits.pop_front());
            gapRun = 0;
            pD1    = modelGray();
        end else if (lineActive) begin
            gapRun++;
            if (gapRun >= GAP_CYC) lineActive = 0;
        end
        pV1 = v;
        @(negedge iCLK);
        checkEq({tag, " dval"}, 32'(oDVAL), 32'(expV));
        checkEq({tag, " data"}, 32'(oDATA), 32'(expD));
    endtask

    task automatic gapCycles(input string tag, input int n);
        for (int i = 0; i < n; i++) stepPixel(tag, 1'b0, 1'b0);
    endtask

    task automatic modelReset();
        lineBits.delete();
        lineActive = 0;
        gapRun     = 0;
        pV1        = 1'b0;
        expV       = 1'b0;
        expD       = 0;
    endtask

    task automatic midReset(input string tag);
        iRST  = 1'b0;
        iDVAL = 1'b0;
        #1;
        checkEq({tag, " rst dval"}, 32'(oDVAL), 32'd0);
        checkEq({tag, " rst data"}, 32'(oDATA), 32'd0);
        @(posedge iCLK);
        @(negedge iCLK);
        iRST = 1'b1;
        modelReset();
    endtask

    initial begin
        iRST  = 1'b0;
        iDVAL = 1'b0;
        iDATA = '0;
        repeat (2) @(negedge iCLK);
        checkEq("por dval", 32'(oDVAL), 32'd0);
        checkEq("por data", 32'(oDATA), 32'd0);
        iRST = 1'b1;
        modelReset();

        for (int i = 0; i < 12; i++) stepPixel("white12", 1'b1, 1'b1);
        gapCycles("white12 tail", 6);

        for (int i = 0; i < 16; i++) stepPixel("alt", 1'b1, 1'(i % 2 == 0));
        for (int i = 0; i < 8; i++) stepPixel("black8", 1'b1, 1'b0);
        gapCycles("alt tail", 6);

        for (int i = 0; i < 8; i++) stepPixel("gap3 line", 1'b1, 1'b1);
        gapCycles("gap3", 3);
        stepPixel("gap3 px", 1'b1, 1'b1);
        gapCycles("gap3 tail", 6);

        for (int i = 0; i < 8; i++) stepPixel("gap4 line", 1'b1, 1'b1);
        gapCycles("gap4", 4);
        stepPixel("gap4 px", 1'b1, 1'b1);
        gapCycles("gap4 tail", 6);

        for (int i = 0; i < 5; i++) stepPixel("edge line", 1'b1, 1'(i % 3 != 2));
        gapCycles("edge gap", GAP_CYC - 1);
        stepPixel("edge px", 1'b1, 1'b0);
        stepPixel("edge px2", 1'b1, 1'b1);
        gapCycles("edge tail", 6);

        stepPixel("blackstart", 1'b1, 1'b0);
        stepPixel("blackstart", 1'b1, 1'b1);
        gapCycles("blackstart tail", 6);

        for (int i = 0; i < 6; i++) stepPixel("pre rst", 1'b1, 1'b1);
        midReset("mid");
        for (int i = 0; i < 4; i++) stepPixel("post rst", 1'b1, 1'(i == 1));
        gapCycles("post rst tail", 6);

        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                gapCycles("rnd gap", int'($urandom_range(GAP_CYC - 1, GAP_CYC + 1)));
            end else begin
                stepPixel("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            end
            if (n == 400) midReset("rnd");
        end
        gapCycles("final", 4);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
